// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funcs,
// datapath select codes, state enumeration and the per-cycle control bundle.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
    ALU_OR  = 3'b011, ALU_SLT = 3'b100
  } alu_ctr_e;

  typedef enum logic [1:0] {
    SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10
  } pc_src_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
    S_WB_R     = 4'd4,  S_EXEC_I = 4'd5,  S_WB_I   = 4'd6,  S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,  S_MEM_WB = 4'd9,  S_MEM_WR = 4'd10, S_BRANCH = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  typedef struct packed {
    logic     pc_wr;
    logic     iord;
    logic     mem_wr;
    logic     ir_wr;
    logic     reg_dst;
    logic     mem_to_reg;
    logic     reg_wr;
    logic     alu_src_a;
    src_b_e   alu_src_b;
    alu_ctr_e alu_ctr;
    pc_src_e  pc_src;
    logic     ext_op;
    logic     instr_done;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in,
// per-cycle enables/selects and debug state out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_rdy;
  logic       pc_wr;
  logic       iord;
  logic       mem_wr;
  logic       ir_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_wr;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctr;
  logic [1:0] pc_src;
  logic       ext_op;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, func, zero, mem_rdy,
    output pc_wr, iord, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
           alu_src_a, alu_src_b, alu_ctr, pc_src, ext_op, instr_done,
           illegal, state
  );

  modport slave (
    output op, func, zero, mem_rdy,
    input  pc_wr, iord, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
           alu_src_a, alu_src_b, alu_ctr, pc_src, ext_op, instr_done,
           illegal, state
  );
endinterface

// File: rtl/mc_alu_dec.sv
// R-type func field to ALU operation; valid_o low for unsupported funcs.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] func_i,
  output alu_ctr_e   alu_ctr_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctr_o = ALU_ADD;
    valid_o   = 1'b1;
    case (func_i)
      FN_ADDU: alu_ctr_o = ALU_ADD;
      FN_SUBU: alu_ctr_o = ALU_SUB;
      FN_AND:  alu_ctr_o = ALU_AND;
      FN_OR:   alu_ctr_o = ALU_OR;
      FN_SLT:  alu_ctr_o = ALU_SLT;
      default: valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Optional MEM_WAIT_EN macro makes FETCH,
// MEM_RD and MEM_WR stall on mem_rdy; otherwise memory is single-cycle.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit RST_PC_HOLD = 1'b0
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);

  state_e   state_q, state_d;
  logic     illegal_q, illegal_d;
  ctl_t     ctl;
  alu_ctr_e fn_ctr;
  logic     fn_ok;
  logic     rdy;

`ifdef MEM_WAIT_EN
  assign rdy = bus.mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = bus.mem_rdy;
  assign rdy = 1'b1;
`endif

  mc_alu_dec u_alu_dec (
    .func_i    (bus.func),
    .alu_ctr_o (fn_ctr),
    .valid_o   (fn_ok)
  );

  always_comb begin
    ctl       = '0;
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ctl.ir_wr     = rdy;
        ctl.pc_wr     = rdy;
        ctl.alu_src_b = SRCB_FOUR;
        if (rdy) state_d = S_DECODE;
      end
      // Branch target is precomputed here so BRANCH only has to compare.
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH2;
        ctl.ext_op    = 1'b1;
        case (bus.op)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ORI, OP_ADDIU: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default: begin
            state_d        = S_FETCH;
            illegal_d      = 1'b1;
            ctl.instr_done = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_ctr   = fn_ctr;
        if (fn_ok) begin
          state_d = S_WB_R;
        end else begin
          state_d        = S_FETCH;
          illegal_d      = 1'b1;
          ctl.instr_done = 1'b1;
        end
      end
      S_WB_R: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_wr     = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_ctr   = (bus.op == OP_ORI) ? ALU_OR : ALU_ADD;
        ctl.ext_op    = (bus.op != OP_ORI);
        state_d       = S_WB_I;
      end
      S_WB_I: begin
        ctl.reg_wr     = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.ext_op    = 1'b1;
        state_d       = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctl.iord = 1'b1;
        if (rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_wr     = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.iord       = 1'b1;
        ctl.mem_wr     = rdy;
        ctl.instr_done = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_ctr    = ALU_SUB;
        ctl.pc_src     = PCSRC_ALUOUT;
        ctl.pc_wr      = bus.zero;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_src     = PCSRC_JUMP;
        ctl.pc_wr      = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset kills every enable immediately, even before the state register settles.
    if (rst) ctl = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_PC_HOLD ? S_IDLE : S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.pc_wr      = ctl.pc_wr;
  assign bus.iord       = ctl.iord;
  assign bus.mem_wr     = ctl.mem_wr;
  assign bus.ir_wr      = ctl.ir_wr;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.reg_wr     = ctl.reg_wr;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_ctr    = ctl.alu_ctr;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.ext_op     = ctl.ext_op;
  assign bus.instr_done = ctl.instr_done;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each issued instruction pushes its expected
// per-cycle control vectors; a negedge monitor pops and compares.
module tb_mc_ctrl;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_wr, iord, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr, src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       ext, done, ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl #(.RST_PC_HOLD(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t exp_q[$];
  bit   dc_q[$];
  bit   chk_en = 1'b0;
  bit   ill_m  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t sample();
    vec_t g;
    g.st = bus.state;   g.pc_wr = bus.pc_wr;     g.iord = bus.iord;
    g.mem_wr = bus.mem_wr; g.ir_wr = bus.ir_wr;  g.reg_dst = bus.reg_dst;
    g.mem_to_reg = bus.mem_to_reg; g.reg_wr = bus.reg_wr; g.src_a = bus.alu_src_a;
    g.src_b = bus.alu_src_b; g.alu = bus.alu_ctr; g.pc_src = bus.pc_src;
    g.ext = bus.ext_op; g.done = bus.instr_done; g.ill = bus.illegal;
    return g;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      vec_t g, e;
      bit dc;
      cyc++;
      g = sample();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow cycle=%0d got=%h exp=none", cyc, g);
      end else begin
        e  = exp_q.pop_front();
        dc = dc_q.pop_front();
        if (dc) begin g.alu = '0; e.alu = '0; end
        if (g !== e) begin
          errors++;
          $display("FAIL ctl_vector cycle=%0d got=%h exp=%h", cyc, g, e);
        end
      end
    end
  end

  task automatic put(input vec_t v, input bit dc);
    v.ill = ill_m;
    exp_q.push_back(v);
    dc_q.push_back(dc);
  endtask

  function automatic bit legal_op(input logic [5:0] o);
    return o inside {OP_RTYPE, OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  // Reference: expected cycle-by-cycle controls straight from the instruction table.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
    vec_t v;
    int   n;
    bit   ill_next;
    bit   bad;
    ill_next = ill_m;
    bad = 1'b0;
    bus.op = o; bus.func = f; bus.zero = z;
    v = '0; v.st = S_FETCH; v.ir_wr = 1; v.pc_wr = 1; v.src_b = 2'b01; put(v, 0);
    v = '0; v.st = S_DECODE; v.src_b = 2'b11; v.ext = 1;
    n = 2;
    if (!legal_op(o)) begin
      v.done = 1; put(v, 0); ill_next = 1;
    end else begin
      put(v, 0);
      v = '0;
      case (o)
        OP_RTYPE: begin
          v.st = S_EXEC_R; v.src_a = 1; n = 3;
          case (f)
            FN_ADDU: v.alu = 3'd0;
            FN_SUBU: v.alu = 3'd1;
            FN_AND:  v.alu = 3'd2;
            FN_OR:   v.alu = 3'd3;
            FN_SLT:  v.alu = 3'd4;
            default: begin bad = 1; v.done = 1; ill_next = 1; end
          endcase
          put(v, bad);
          if (!bad) begin
            v = '0; v.st = S_WB_R; v.reg_dst = 1; v.reg_wr = 1; v.done = 1; put(v, 0); n = 4;
          end
        end
        OP_ORI, OP_ADDIU: begin
          v.st = S_EXEC_I; v.src_a = 1; v.src_b = 2'b10;
          v.alu = (o == OP_ORI) ? 3'd3 : 3'd0; v.ext = (o == OP_ADDIU); put(v, 0);
          v = '0; v.st = S_WB_I; v.reg_wr = 1; v.done = 1; put(v, 0); n = 4;
        end
        OP_LW, OP_SW: begin
          v.st = S_MEM_ADDR; v.src_a = 1; v.src_b = 2'b10; v.ext = 1; put(v, 0);
          v = '0;
          if (o == OP_LW) begin
            v.st = S_MEM_RD; v.iord = 1; put(v, 0);
            v = '0; v.st = S_MEM_WB; v.mem_to_reg = 1; v.reg_wr = 1; v.done = 1; put(v, 0); n = 5;
          end else begin
            v.st = S_MEM_WR; v.iord = 1; v.mem_wr = 1; v.done = 1; put(v, 0); n = 4;
          end
        end
        OP_BEQ: begin
          v.st = S_BRANCH; v.src_a = 1; v.alu = 3'd1; v.pc_src = 2'b01; v.pc_wr = z;
          v.done = 1; put(v, 0); n = 3;
        end
        default: begin
          v.st = S_JUMP; v.pc_src = 2'b10; v.pc_wr = 1; v.done = 1; put(v, 0); n = 3;
        end
      endcase
    end
    ill_m = ill_next;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    logic [5:0]  o, f;
    logic [5:0]  fn_tab [5];
    fn_tab[0] = FN_ADDU; fn_tab[1] = FN_SUBU; fn_tab[2] = FN_AND;
    fn_tab[3] = FN_OR;   fn_tab[4] = FN_SLT;

    rst = 1'b1;
    bus.op = '0; bus.func = '0; bus.zero = 1'b0; bus.mem_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", bus.state, S_FETCH);
    chk("reset_enables", {bus.pc_wr, bus.mem_wr, bus.ir_wr, bus.reg_wr, bus.instr_done}, 0);
    chk("reset_selects", {bus.iord, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                          bus.alu_src_b, bus.alu_ctr, bus.pc_src, bus.ext_op}, 0);
    chk("reset_illegal", bus.illegal, 0);

    rst = 1'b0;
    chk_en = 1'b1;
    issue(OP_RTYPE, FN_ADDU, 0);
    issue(OP_LW, 6'h00, 0);
    issue(OP_SW, 6'h00, 1);
    issue(OP_BEQ, 6'h00, 1);
    issue(OP_BEQ, 6'h00, 0);
    issue(OP_J, 6'h00, 0);
    issue(OP_ORI, 6'h00, 0);
    issue(OP_ADDIU, 6'h00, 1);
    issue(OP_RTYPE, FN_SLT, 0);
    issue(6'b111111, 6'h00, 0);
    issue(OP_RTYPE, FN_SUBU, 0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      f = 6'h00;
      case (r)
        0, 1, 9: begin
          o = OP_RTYPE;
          if ($urandom_range(0, 7) == 0) begin
            do begin r = $urandom(); f = r[5:0]; end
            while (f inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT});
          end else begin
            f = fn_tab[$urandom_range(0, 4)];
          end
        end
        2: o = OP_ORI;
        3: o = OP_ADDIU;
        4: o = OP_LW;
        5: o = OP_SW;
        6: o = OP_BEQ;
        7: o = OP_J;
        default: begin
          do begin r = $urandom(); o = r[5:0]; end while (legal_op(o));
        end
      endcase
      r = $urandom();
      issue(o, f, r[0]);
    end
    chk_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);

    // Abort a store in MEM_WR with an asynchronous reset.
    bus.op = OP_SW;
    repeat (3) @(posedge clk);
    #1;
    chk("sw_in_mem_wr", bus.state, S_MEM_WR);
    chk("sw_mem_wr_high", bus.mem_wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_wr_low", bus.mem_wr, 0);
    chk("rst_state_fetch", bus.state, S_FETCH);
    chk("rst_ir_wr_low", bus.ir_wr, 0);
    chk("rst_illegal_clr", bus.illegal, 0);
    @(posedge clk);
    #1;
    bus.mem_rdy = 1'b0;
    rst = 1'b0;
`ifdef MEM_WAIT_EN
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait_state_held", bus.state, S_FETCH);
      chk("wait_ir_wr_low", bus.ir_wr, 0);
      chk("wait_pc_wr_low", bus.pc_wr, 0);
      @(posedge clk);
      #1;
    end
`endif
    bus.mem_rdy = 1'b1;
    #1;
    chk("fetch_ir_wr", bus.ir_wr, 1);
    chk("fetch_pc_wr", bus.pc_wr, 1);
    @(posedge clk);
    #1;
    chk("fetch_to_decode", bus.state, S_DECODE);
    chk("illegal_after_rst", bus.illegal, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
